atari_bus_sequencer: RTL and testbench
======================================

# atari_bus_sequencer

Clock-enable generator and bus scheduler for the Atari 2600 core. It divides the single VGA pixel clock into a 21-phase machine cycle and issues the TIA, CPU and PIA enables. It decodes the CPU address bus into chip selects and a registered read-source code. It applies the WSYNC stall and freezes the whole machine between TIA end-of-frame and the next VGA vsync.

## Interface
Parameters:
- `PHASES`, 21: phases per CPU machine cycle.
- `TIA_PH0` / `TIA_PH1` / `TIA_PH2`, 0 / 7 / 14: phases that carry `tia_en`.
- `CPU_PH`, 0: phase that carries `cpu_en`.
- `PIA_PH`, 16: phase that carries `pia_en`.
- `FRAME_LOCK`, 1: 1 enables the frame-wait state; 0 never enters it.

Ports:
- `clk` in 1: VGA pixel clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hold_phase` in 1: forces the phase counter to 0, used while VGA x ≤ 1 for scanline alignment.
- `vga_vsync` in 1: VGA vertical sync, active-high.
- `tia_vsync` in 1: TIA VSYNC output.
- `tia_stall` in 1: TIA WSYNC stall request.
- `addr` in 16: CPU address bus.
- `we` in 1: CPU write enable.
- `phase` out 5: current phase, 0..PHASES-1.
- `tia_en` out 1: TIA clock enable.
- `cpu_en` out 1: CPU machine-cycle strobe.
- `pia_en` out 1: PIA clock enable.
- `cpu_rdy` out 1: CPU RDY.
- `ram_cs` / `rom_cs` / `tia_cs` / `pia_cs` out 1 each: combinational chip selects.
- `ram_we` out 1: RAM write strobe.
- `rd_src` out 3: registered read-source code.
- `frame_wait` out 1: high while in the WAIT state.
- `frame_count` out 8: number of completed frame-wait exits.

## Operation
Phase counter:
- Next value is 0 if `hold_phase` is high.
- Otherwise next value is 0 if `phase == PHASES-1`.
- Otherwise next value is `phase + 1`.
- The counter runs in both states.

State machine, with states RUN and WAIT:
- `vs_d` is `tia_vsync` registered on `clk`.
- RUN -> WAIT when `FRAME_LOCK` is 1 and `vs_d & ~tia_vsync` (TIA vsync falling edge).
- WAIT -> RUN when `vga_vsync` is high; `frame_count` increments on this transition.
- If the falling edge and `vga_vsync` are both high in the same cycle while in RUN, the state stays RUN and `frame_count` is unchanged.
- While in WAIT, further `tia_vsync` edges are ignored.

Enables (combinational from registered `phase` and state, and gated by `rst_n`):
- `tia_en` = RUN and `phase` is one of TIA_PH0, TIA_PH1 or TIA_PH2.
- `pia_en` = RUN and `phase == PIA_PH`.
- `cpu_en` = RUN and `phase == CPU_PH` and `~tia_stall`.
- `cpu_rdy` = RUN and `~tia_stall`.
- `tia_en` keeps running during a stall, so the TIA can reach the end of the line and drop `tia_stall`.

Address decode (combinational, `addr[15:13]` ignored so mirrors decode identically):
- `ram_cs` = `addr[12:7] == 6'b000001`.
- `rom_cs` = `addr[12]`.
- `tia_cs` = `addr[12:6] == 0`.
- `pia_cs` = `addr[12:5] == 8'b00010100`.
- `ram_we` = `cpu_en & we & ram_cs`.

Read-source code:
- `rd_src` is loaded only on cycles where `cpu_en` is high, and holds otherwise.
- Codes: 0 = none (pull-down), 1 = RAM, 2 = ROM, 3 = TIA, 4 = PIA.
- Priority when loading is PIA > TIA > ROM > RAM > none.

## Timing
Reset (while `rst_n` low, asynchronous):
- `phase` = 0, state = RUN, `vs_d` = 0, `rd_src` = 0, `frame_count` = 0.
- All enables, `cpu_rdy`, `ram_we` and `frame_wait` are 0.
- Chip selects still follow `addr`.
- Reset asserted during WAIT returns the block to RUN.

Cycle behaviour:
- The first `cpu_en` after reset release occurs at the first cycle where `phase == CPU_PH`, i.e. the release cycle itself if `phase` is 0.
- `rd_src` becomes valid one clock after the `cpu_en` cycle and stays stable for the following 20 cycles.
- Entry to WAIT takes effect one clock after the falling edge is sampled, so the enables are 0 from that cycle.
- Exit from WAIT takes effect one clock after `vga_vsync` is sampled high.
- `frame_count` wraps from 255 to 0.
- With `hold_phase` low, `cpu_en` period is exactly `PHASES` clocks.

## Test plan
- Free run after reset with no stall: `tia_en` at phases 0/7/14 (3 per 21 clocks), `cpu_en` at phase 0, `pia_en` at phase 16, `cpu_en` period 21.
- Hold `hold_phase` for 2 clocks at phase 9: `phase` reads 0, 0, then 1; the next `cpu_en` falls 21 clocks after the release point.
- Raise `tia_stall` for 50 clocks: `cpu_rdy` = 0, no `cpu_en`, `tia_en` keeps pulsing; `cpu_en` resumes at the first phase 0 after `tia_stall` drops.
- Drive `tia_vsync` 1 -> 0, then `vga_vsync` high 300 clocks later: `frame_wait` = 1 with all enables 0 during the wait, then RUN, `frame_count` 0 -> 1. Also drive the falling edge and `vga_vsync` together: no WAIT entry.
- Decode: `addr` 0x0085 with `we` = 1 at `cpu_en` -> `ram_we` pulses for one clock and `rd_src` = 1. `addr` 0xF123 -> `rd_src` = 2. `addr` 0x0284 -> `pia_cs` and `rd_src` = 4. `addr` 0x0009 -> 3. `addr` 0x0180 -> 0.
- Assert `rst_n` low mid-WAIT with `frame_count` = 255: outputs go to reset values immediately; after release the block is in RUN with `frame_count` = 0.

Source files
------------

// File: rtl/atari_bus_sequencer_if.sv
// Bus bundle between the Atari 2600 core glue and the bus sequencer.
// Latency: n/a (wires only).
// Backpressure: n/a; the stall travels as tia_stall / cpu_rdy.
interface atari_bus_sequencer_if;
    logic        hold_phase;
    logic        vga_vsync;
    logic        tia_vsync;
    logic        tia_stall;
    logic [15:0] addr;
    logic        we;
    logic [4:0]  phase;
    logic        tia_en;
    logic        cpu_en;
    logic        pia_en;
    logic        cpu_rdy;
    logic        ram_cs;
    logic        rom_cs;
    logic        tia_cs;
    logic        pia_cs;
    logic        ram_we;
    logic [2:0]  rd_src;
    logic        frame_wait;
    logic [7:0]  frame_count;

    // Driver side: the CPU/TIA/VGA glue that feeds the sequencer.
    modport master (
        output hold_phase, vga_vsync, tia_vsync, tia_stall, addr, we,
        input  phase, tia_en, cpu_en, pia_en, cpu_rdy, ram_cs, rom_cs, tia_cs,
               pia_cs, ram_we, rd_src, frame_wait, frame_count
    );

    // Sequencer side.
    modport slave (
        input  hold_phase, vga_vsync, tia_vsync, tia_stall, addr, we,
        output phase, tia_en, cpu_en, pia_en, cpu_rdy, ram_cs, rom_cs, tia_cs,
               pia_cs, ram_we, rd_src, frame_wait, frame_count
    );
endinterface

// File: rtl/atari_bus_sequencer.sv
// Divides the pixel clock into a 21-phase machine cycle, issues TIA/CPU/PIA enables, decodes the CPU bus.
// Latency: enables/chip selects combinational from registered phase; rd_src registered one clock after cpu_en.
// Backpressure: tia_stall drops cpu_rdy/cpu_en (TIA keeps running); frame-wait freezes all enables until vga_vsync.
module atari_bus_sequencer #(
    parameter int PHASES     = 21,
    parameter int TIA_PH0    = 0,
    parameter int TIA_PH1    = 7,
    parameter int TIA_PH2    = 14,
    parameter int CPU_PH     = 0,
    parameter int PIA_PH     = 16,
    parameter int FRAME_LOCK = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    atari_bus_sequencer_if.slave bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [4:0] PH_LAST = 5'(PHASES - 1);
    localparam logic [4:0] PH_TIA0 = 5'(TIA_PH0);
    localparam logic [4:0] PH_TIA1 = 5'(TIA_PH1);
    localparam logic [4:0] PH_TIA2 = 5'(TIA_PH2);
    localparam logic [4:0] PH_CPU  = 5'(CPU_PH);
    localparam logic [4:0] PH_PIA  = 5'(PIA_PH);

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_RAM  = 3'd1;
    localparam logic [2:0] SRC_ROM  = 3'd2;
    localparam logic [2:0] SRC_TIA  = 3'd3;
    localparam logic [2:0] SRC_PIA  = 3'd4;

    logic [4:0] phase;
    logic [0:0] state;
    logic       vs_d;
    logic [2:0] rd_src;
    logic [7:0] frame_count;

    logic       running;
    logic       vs_fall;
    logic       cpu_en;
    logic       ram_cs;
    logic       rom_cs;
    logic       tia_cs;
    logic       pia_cs;
    logic [2:0] src_next;

    // Enables only exist while running and out of reset.
    assign running = (state == ST_RUN) && rst_n;
    assign vs_fall = vs_d && !bus.tia_vsync;
    assign cpu_en  = running && (phase == PH_CPU) && !bus.tia_stall;

    // addr[15:13] is not wired on the cartridge bus, so mirrors decode identically.
    assign ram_cs = (bus.addr[12:7] == 6'b000001);
    assign rom_cs = bus.addr[12];
    assign tia_cs = (bus.addr[12:6] == 7'd0);
    assign pia_cs = (bus.addr[12:5] == 8'b00010100);

    // Read-source priority: PIA over TIA over ROM over RAM.
    always_comb begin
        src_next = SRC_NONE;
        if (pia_cs)      src_next = SRC_PIA;
        else if (tia_cs) src_next = SRC_TIA;
        else if (rom_cs) src_next = SRC_ROM;
        else if (ram_cs) src_next = SRC_RAM;
    end

    // Phase counter; hold_phase realigns it to the scanline start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                phase <= 5'd0;
        else if (bus.hold_phase)   phase <= 5'd0;
        else if (phase == PH_LAST) phase <= 5'd0;
        else                       phase <= phase + 5'd1;
    end

    // Frame lock: park after the TIA finishes a frame until VGA starts the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            vs_d        <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            vs_d <= bus.tia_vsync;
            if (state == ST_RUN) begin
                // A coincident VGA vsync means we are already aligned: stay running.
                if ((FRAME_LOCK != 0) && vs_fall && !bus.vga_vsync)
                    state <= ST_WAIT;
            end else if (bus.vga_vsync) begin
                state       <= ST_RUN;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Read source is captured on the CPU strobe and held for the whole machine cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_src <= SRC_NONE;
        else if (cpu_en) rd_src <= src_next;
    end

    assign bus.phase       = phase;
    assign bus.tia_en      = running && ((phase == PH_TIA0) || (phase == PH_TIA1) || (phase == PH_TIA2));
    assign bus.pia_en      = running && (phase == PH_PIA);
    assign bus.cpu_en      = cpu_en;
    assign bus.cpu_rdy     = running && !bus.tia_stall;
    assign bus.ram_cs      = ram_cs;
    assign bus.rom_cs      = rom_cs;
    assign bus.tia_cs      = tia_cs;
    assign bus.pia_cs      = pia_cs;
    assign bus.ram_we      = cpu_en && bus.we && ram_cs;
    assign bus.rd_src      = rd_src;
    assign bus.frame_wait  = (state == ST_WAIT) && rst_n;
    assign bus.frame_count = frame_count;
endmodule

// File: tb/tb_atari_bus_sequencer.sv
// Bench for atari_bus_sequencer: directed vectors plus a per-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_atari_bus_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    atari_bus_sequencer_if bus();

    atari_bus_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: machine position, frame mode, last tia_vsync, frames, captured source.
    int  m_phase = 0;
    bit  m_waiting = 0;
    bit  m_vs = 0;
    int  m_frames = 0;
    int  m_src = 0;

    function automatic int src_of(input logic [15:0] a);
        int low;
        low = int'(a) % 8192;
        if (low >= 'h280 && low <= 'h29F) return 4;
        if (low < 'h40)                   return 3;
        if (low >= 'h1000)                return 2;
        if (low >= 'h80 && low <= 'hFF)   return 1;
        return 0;
    endfunction

    function automatic bit m_live();
        return !m_waiting && (rst_n === 1'b1);
    endfunction

    function automatic bit m_cpu_en();
        return m_live() && m_phase == 0 && !bus.tia_stall;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_waiting = 0; m_vs = 0; m_frames = 0; m_src = 0;
        end else begin
            if (m_cpu_en()) m_src = src_of(bus.addr);
            if (!m_waiting) begin
                if (m_vs && !bus.tia_vsync && !bus.vga_vsync) m_waiting = 1;
            end else if (bus.vga_vsync) begin
                m_waiting = 0;
                m_frames = (m_frames + 1) % 256;
            end
            m_vs = bus.tia_vsync;
            m_phase = bus.hold_phase ? 0 : (m_phase + 1) % 21;
        end
    end

    // Every cycle, all outputs against the model.
    always @(negedge clk) begin
        int a;
        a = int'(bus.addr) % 8192;
        chk("m_phase", int'(bus.phase), m_phase);
        chk("m_tia_en", int'(bus.tia_en), int'(m_live() && (m_phase == 0 || m_phase == 7 || m_phase == 14)));
        chk("m_pia_en", int'(bus.pia_en), int'(m_live() && m_phase == 16));
        chk("m_cpu_en", int'(bus.cpu_en), int'(m_cpu_en()));
        chk("m_cpu_rdy", int'(bus.cpu_rdy), int'(m_live() && !bus.tia_stall));
        chk("m_ram_cs", int'(bus.ram_cs), int'(a >= 'h80 && a <= 'hFF));
        chk("m_rom_cs", int'(bus.rom_cs), int'(a >= 'h1000));
        chk("m_tia_cs", int'(bus.tia_cs), int'(a < 'h40));
        chk("m_pia_cs", int'(bus.pia_cs), int'(a >= 'h280 && a <= 'h29F));
        chk("m_ram_we", int'(bus.ram_we), int'(m_cpu_en() && bus.we && a >= 'h80 && a <= 'hFF));
        chk("m_rd_src", int'(bus.rd_src), m_src);
        chk("m_frame_wait", int'(bus.frame_wait), int'(m_waiting && rst_n));
        chk("m_frame_count", int'(bus.frame_count), m_frames);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until cpu_en is high; n = clocks taken.
    task automatic wait_cpu(input string nm, output int n);
        n = 0;
        while (bus.cpu_en !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (bus.cpu_en !== 1'b1) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic frame_cycle();
        bus.tia_vsync = 1'b1; tick();
        bus.tia_vsync = 1'b0; tick();
        bus.vga_vsync = 1'b1; tick();
        bus.vga_vsync = 1'b0; tick();
    endtask

    initial begin
        int n, c_tia, c_cpu, c_pia;
        bus.hold_phase = 0; bus.vga_vsync = 0; bus.tia_vsync = 0;
        bus.tia_stall = 0; bus.addr = 16'h0180; bus.we = 0;
        tick(); tick();
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_cpu_en", int'(bus.cpu_en), 0);
        chk("rst_rd_src", int'(bus.rd_src), 0);
        rst_n = 1'b1;
        #1;
        chk("first_cpu_en", int'(bus.cpu_en), 1);

        // Free run: one machine cycle of enables.
        c_tia = 0; c_cpu = 0; c_pia = 0;
        for (int i = 0; i < 21; i++) begin
            c_tia += int'(bus.tia_en); c_cpu += int'(bus.cpu_en); c_pia += int'(bus.pia_en);
            tick();
        end
        chk("free_tia_cnt", c_tia, 3);
        chk("free_cpu_cnt", c_cpu, 1);
        chk("free_pia_cnt", c_pia, 1);
        tick();
        wait_cpu("period", n);
        chk("cpu_period", n, 20);

        // Hold at phase 9.
        n = 0;
        while (bus.phase != 5'd9 && n < 50) begin tick(); n++; end
        chk("reach_ph9", int'(bus.phase), 9);
        bus.hold_phase = 1; tick();
        chk("hold_ph_a", int'(bus.phase), 0);
        tick();
        chk("hold_ph_b", int'(bus.phase), 0);
        bus.hold_phase = 0; tick();
        chk("hold_ph_c", int'(bus.phase), 1);
        wait_cpu("hold", n);
        chk("hold_cpu_gap", n + 1, 21);

        // WSYNC stall.
        bus.tia_stall = 1;
        c_tia = 0; c_cpu = 0; c_pia = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            c_tia += int'(bus.tia_en); c_cpu += int'(bus.cpu_en); c_pia += int'(bus.cpu_rdy);
        end
        chk("stall_cpu_en", c_cpu, 0);
        chk("stall_rdy", c_pia, 0);
        chk("stall_tia_runs", int'(c_tia >= 7), 1);
        bus.tia_stall = 0;
        wait_cpu("stall_resume", n);
        chk("resume_phase", int'(bus.phase), 0);

        // Frame wait.
        bus.tia_vsync = 1; tick();
        bus.tia_vsync = 0; tick();
        chk("wait_entered", int'(bus.frame_wait), 1);
        c_tia = 0;
        for (int i = 0; i < 300; i++) begin
            c_tia += int'(bus.tia_en) + int'(bus.cpu_en) + int'(bus.pia_en) + int'(bus.cpu_rdy);
            tick();
        end
        chk("wait_enables", c_tia, 0);
        bus.vga_vsync = 1; tick();
        bus.vga_vsync = 0;
        chk("wait_exit", int'(bus.frame_wait), 0);
        chk("frame_count_1", int'(bus.frame_count), 1);
        bus.tia_vsync = 1; tick();
        bus.tia_vsync = 0; bus.vga_vsync = 1; tick();
        bus.vga_vsync = 0; tick();
        chk("coincident_no_wait", int'(bus.frame_wait), 0);
        chk("coincident_count", int'(bus.frame_count), 1);

        // Decode / read source.
        bus.addr = 16'h0085; bus.we = 1;
        tick();
        wait_cpu("dec_ram", n);
        chk("ram_we_pulse", int'(bus.ram_we), 1);
        tick();
        chk("ram_we_off", int'(bus.ram_we), 0);
        chk("src_ram", int'(bus.rd_src), 1);
        bus.we = 0;
        bus.addr = 16'hF123; wait_cpu("dec_rom", n); tick();
        chk("src_rom", int'(bus.rd_src), 2);
        for (int i = 0; i < 19; i++) tick();
        chk("src_rom_held", int'(bus.rd_src), 2);
        bus.addr = 16'h0284;
        chk("pia_cs", int'(bus.pia_cs), 1);
        wait_cpu("dec_pia", n); tick();
        chk("src_pia", int'(bus.rd_src), 4);
        bus.addr = 16'h0009; wait_cpu("dec_tia", n); tick();
        chk("src_tia", int'(bus.rd_src), 3);
        bus.addr = 16'h0180; wait_cpu("dec_none", n); tick();
        chk("src_none", int'(bus.rd_src), 0);

        // Reset during WAIT with frame_count 255.
        for (int i = 0; i < 254; i++) frame_cycle();
        chk("frame_count_255", int'(bus.frame_count), 255);
        bus.tia_vsync = 1; tick();
        bus.tia_vsync = 0; tick();
        chk("wait_at_255", int'(bus.frame_wait), 1);
        bus.addr = 16'hF000;
        #2;
        rst_n = 0;
        #1;
        chk("arst_wait", int'(bus.frame_wait), 0);
        chk("arst_count", int'(bus.frame_count), 0);
        chk("arst_rom_cs", int'(bus.rom_cs), 1);
        tick();
        rst_n = 1;
        tick();
        chk("post_rst_run", int'(bus.frame_wait), 0);
        chk("post_rst_count", int'(bus.frame_count), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
